// File: rtl/draw_rect_gen.sv
// ============================================================================
// Module   : draw_rect_gen
// Purpose  : Streams every point of an outline or filled rectangle in raster
//            order over a valid/ready interface.
// Revision : 1.0
// ============================================================================
`default_nettype none

module draw_rect_gen #(
   parameter int DATA_W = 32
) (
   input  logic              _clock,
   input  logic              _reset,
   input  logic              _start,
   input  logic [DATA_W-1:0] s_x,
   input  logic [DATA_W-1:0] s_y,
   input  logic [DATA_W-1:0] height,
   input  logic [DATA_W-1:0] width,
   input  logic              fill,
   input  logic              _ready,
   output logic              _valid,
   output logic [DATA_W-1:0] _out0,
   output logic [DATA_W-1:0] _out1,
   output logic              _busy,
   output logic              _done
);

   localparam logic [DATA_W-1:0] c_one = DATA_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_x, r_y, r_h_last, r_w_last;
   logic              r_fill;
   logic [DATA_W-1:0] r_row, r_col;

   logic [DATA_W-1:0] w_next_row, w_next_col;
   logic              w_last;

   // Interior outline rows jump straight from the left edge to the right edge.
   always_comb begin
      w_next_row = r_row;
      w_next_col = r_col;
      w_last     = (r_row == r_h_last) && (r_col == r_w_last);
      if (r_col == r_w_last) begin
         w_next_row = r_row + c_one;
         w_next_col = '0;
      end else if (r_fill || (r_row == '0) || (r_row == r_h_last)) begin
         w_next_col = r_col + c_one;
      end else begin
         w_next_col = r_w_last;
      end
   end

   always_ff @(posedge _clock or posedge _reset) begin
      if (_reset) begin
         r_state  <= S_IDLE;
         r_x      <= '0;
         r_y      <= '0;
         r_h_last <= '0;
         r_w_last <= '0;
         r_fill   <= 1'b0;
         r_row    <= '0;
         r_col    <= '0;
         _valid   <= 1'b0;
         _out0    <= '0;
         _out1    <= '0;
         _busy    <= 1'b0;
         _done    <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (!_valid) begin
                  // First cycle after the accept loads the origin point.
                  _valid <= 1'b1;
                  _out0  <= r_x + r_row;
                  _out1  <= r_y + r_col;
               end else if (_ready) begin
                  if (w_last) begin
                     _valid  <= 1'b0;
                     _busy   <= 1'b0;
                     _done   <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_row <= w_next_row;
                     r_col <= w_next_col;
                     _out0 <= r_x + w_next_row;
                     _out1 <= r_y + w_next_col;
                  end
               end
            end
            default: begin
               if (_start) begin
                  r_x      <= s_x;
                  r_y      <= s_y;
                  r_h_last <= height - c_one;
                  r_w_last <= width - c_one;
                  r_fill   <= fill;
                  r_row    <= '0;
                  r_col    <= '0;
                  _valid   <= 1'b0;
                  _done    <= 1'b0;
                  if ((height == '0) || (width == '0)) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_RUN;
                     _busy   <= 1'b1;
                  end
               end else if (r_state == S_DONE) begin
                  _done <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_draw_rect_gen.sv
// ============================================================================
// Module   : tb_draw_rect_gen
// Purpose  : Self-checking bench for draw_rect_gen against a raster-loop model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_draw_rect_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] s_x, s_y, height, width;
   logic        fill;
   logic        ready;
   logic        valid;
   logic [31:0] out0, out1;
   logic        busy, done;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   draw_rect_gen #(.DATA_W(32)) dut (
      ._clock (clk),
      ._reset (rst),
      ._start (start),
      .s_x    (s_x),
      .s_y    (s_y),
      .height (height),
      .width  (width),
      .fill   (fill),
      ._ready (ready),
      ._valid (valid),
      ._out0  (out0),
      ._out1  (out1),
      ._busy  (busy),
      ._done  (done)
   );

   typedef struct {
      logic [31:0] x, y, h, w;
      logic        f;
      int          n;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected point list straight from the geometric definition.
   task automatic build_model(input logic [31:0] x, y, h, w, input logic f,
                              output logic [31:0] qx[$], output logic [31:0] qy[$]);
      qx = {};
      qy = {};
      for (longint r = 0; r < longint'(h); r++)
         for (longint c = 0; c < longint'(w); c++)
            if (f || r == 0 || r == longint'(h) - 1 || c == 0 || c == longint'(w) - 1) begin
               qx.push_back(x + 32'(r));
               qy.push_back(y + 32'(c));
            end
   endtask

   task automatic run_job(input logic [31:0] x, y, h, w, input logic f,
                          input int exp_n, input bit rnd, input bit poke);
      logic [31:0] qx[$], qy[$];
      logic [31:0] p0, p1;
      int          model_n, hs, done_k;
      bit          stall;
      build_model(x, y, h, w, f, qx, qy);
      model_n = qx.size();
      s_x = x; s_y = y; height = h; width = w; fill = f;
      start = 1'b1;
      ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_accept", busy, (h != 0 && w != 0));
      chk("valid_after_accept", valid, 0);
      chk("done_cleared", done, 0);
      hs = 0; done_k = 0; stall = 1'b0; p0 = '0; p1 = '0;
      for (int k = 1; k <= 3000; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (stall) begin
            chk("stall_valid", valid, 1);
            chk("stall_out0", out0, p0);
            chk("stall_out1", out1, p1);
         end
         if (done) begin
            done_k = k;
            break;
         end
         ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stall = valid && !ready;
         p0 = out0; p1 = out1;
         if (valid && ready) begin
            hs++;
            if (qx.size() == 0) begin
               chk("extra_point", 1, 0);
            end else begin
               chk("point_x", out0, qx.pop_front());
               chk("point_y", out1, qy.pop_front());
            end
         end
         if (poke && k == 1) begin
            start = 1'b1;
            s_x = ~x; s_y = ~y; height = 32'd9; width = 32'd9; fill = ~f;
         end
      end
      if (done_k == 0) chk("done_timeout", 0, 1);
      if (exp_n >= 0) chk("point_count", hs, exp_n);
      chk("points_missing", qx.size(), 0);
      chk("valid_at_done", valid, 0);
      chk("busy_at_done", busy, 0);
      if (!rnd) chk("done_latency", done_k, model_n + 1);
   endtask

   vec_t vecs[9];

   initial begin
      rst = 1'b1; start = 1'b0; ready = 1'b0; fill = 1'b0;
      s_x = '0; s_y = '0; height = '0; width = '0;
      vecs[0] = '{32'd10, 32'd20, 32'd3, 32'd4, 1'b0, 10};
      vecs[1] = '{32'd0,  32'd0,  32'd2, 32'd2, 1'b1, 4};
      vecs[2] = '{32'd5,  32'd5,  32'd0, 32'd5, 1'b0, 0};
      vecs[3] = '{32'd7,  32'd9,  32'd1, 32'd3, 1'b0, 3};
      vecs[4] = '{32'd3,  32'd3,  32'd4, 32'd1, 1'b0, 4};
      vecs[5] = '{32'hFFFF_FFFF, 32'd8, 32'd2, 32'd1, 1'b1, 2};
      vecs[6] = '{32'd1,  32'd1,  32'd5, 32'd0, 1'b1, 0};
      vecs[7] = '{32'd0,  32'd0,  32'd5, 32'd5, 1'b0, 16};
      vecs[8] = '{32'd2,  32'd3,  32'd3, 32'd3, 1'b1, 9};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_out0", out0, 0);
      chk("rst_out1", out1, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++)
         run_job(vecs[i].x, vecs[i].y, vecs[i].h, vecs[i].w, vecs[i].f, vecs[i].n, 1'b0, 1'b0);

      // Backpressure on the outline case.
      run_job(32'd10, 32'd20, 32'd3, 32'd4, 1'b0, 10, 1'b1, 1'b0);
      // Wrap with a start pulse during RUN that must be ignored.
      run_job(32'hFFFF_FFFF, 32'd8, 32'd2, 32'd1, 1'b1, 2, 1'b0, 1'b1);
      run_job(32'd40, 32'd50, 32'd3, 32'd5, 1'b0, 12, 1'b1, 1'b1);

      // Reset in the middle of a job.
      s_x = 32'd10; s_y = 32'd20; height = 32'd3; width = 32'd4; fill = 1'b0;
      ready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_reset_valid", valid, 1);
      chk("pre_reset_point", {out0, out1}, {32'd10, 32'd23});
      rst = 1'b1;
      #1;
      chk("async_rst_valid", valid, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_done", done, 0);
      chk("async_rst_out0", out0, 0);
      chk("async_rst_out1", out1, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_valid", valid, 0);
      run_job(32'd10, 32'd20, 32'd3, 32'd4, 1'b0, 10, 1'b0, 1'b0);

      for (int j = 0; j < 20; j++)
         run_job($urandom, $urandom, 32'($urandom_range(0, 6)), 32'($urandom_range(0, 6)),
                 1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)), 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/draw_rect_gen.md
# draw_rect_gen

Parametrised rectangle point generator, successor to the fixed 32-bit outline-only rectangle drawer. It emits every point of an axis-aligned rectangle, either outline or filled, once each in raster order, over a valid/ready stream. The stream feeds the framebuffer write path. Geometry is latched at start, the data width is a parameter, and the consumer can apply backpressure.

## Interface
- DATA_W, default 32: width of coordinates, sizes and outputs.
- _clock  in  1  rising-edge clock.
- _reset  in  1  asynchronous, active-high reset.
- _start  in  1  pulse; accepted only when not busy.
- s_x  in  DATA_W  origin along the height (row) axis.
- s_y  in  DATA_W  origin along the width (column) axis.
- height  in  DATA_W  row count.
- width  in  DATA_W  column count.
- fill  in  1  1 = filled, 0 = outline.
- _ready  in  1  consumer accepts the current point.
- _valid  out  1  _out0/_out1 hold a valid point.
- _out0  out  DATA_W  s_x + r.
- _out1  out  DATA_W  s_y + c.
- _busy  out  1  a job is in progress.
- _done  out  1  the last job completed; sticky until the next accepted _start.

## Operation
- States: IDLE, RUN, DONE. _busy is 1 only in RUN.
- IDLE/DONE with _start=1:
  - latch s_x, s_y, height, width, fill; clear _done.
  - if height==0 or width==0, go to DONE directly (no points);
  - otherwise set r=0, c=0 and enter RUN.
- _start is ignored in RUN. Input changes after the accept have no effect.
- Raster order: r = 0..height-1 outer, c = 0..width-1 inner.
- Point set:
  - Filled emits all height*width points.
  - Outline emits a point only if r==0, r==height-1, c==0 or c==width-1.
  - On an interior row, c steps 0 → width-1 directly, so skipped points cost no cycles.
  - Every point is emitted exactly once, with no duplicated corners.
  - Outline count: h*w if h==1 or w==1, else 2h+2w-4.
- Advance only on handshake (_valid && _ready). After the last point (r==height-1, c==width-1) handshakes, go to DONE.
- Arithmetic is modulo 2^DATA_W: sums wrap silently; sizes are unsigned.
- Row/column counters are DATA_W bits; compare against the latched size minus 1.

## Timing
- Reset values: _valid=0, _done=0, _busy=0, _out0=0, _out1=0; state IDLE.
- Reset asserted mid-job aborts it immediately (asynchronous), with no further points and no _done.
- Start-to-first-point: _start accepted at edge N gives _valid=1 with point (s_x, s_y) after edge N+1.
- Throughput is one point per cycle while _ready=1, regardless of skipped interior points.
- Backpressure: while _valid && !_ready, _out0/_out1/_valid hold stable. _valid never drops without a handshake.
- Last handshake at edge M gives _valid=0, _busy=0, _done=1 after edge M. Zero-size job: _done=1 after edge N+1.
- _done=1 and _start=1 in the same cycle is a new accept: _done goes to 0 next cycle.

## Test plan
- Outline, s_x=10, s_y=20, h=3, w=4, fill=0, _ready=1 → 10 points in consecutive cycles, in this order:
  - (10,20) (10,21) (10,22) (10,23)
  - (11,20) (11,23)
  - (12,20) (12,21) (12,22) (12,23)
  - then _done=1 on the next cycle.
- Filled, (0,0), h=2, w=2, fill=1 → (0,0) (0,1) (1,0) (1,1) on cycles N+1..N+4; _done=1 at N+5.
- Backpressure: repeat the first case with _ready toggling pseudo-randomly → identical sequence. Outputs are stable during every stall; total handshakes = 10.
- Degenerate sizes, each checked for point count and _done:
  - h=0, w=5 → no _valid, _done at N+1.
  - h=1, w=3, outline → 3 points.
  - h=4, w=1, outline → 4 points.
- Wrap and busy-start: s_x = 2^DATA_W-1, h=2, fill=1, w=1 → (2^DATA_W-1, s_y) then (0, s_y). A _start pulse with new geometry during RUN is ignored.
- Reset mid-job: assert _reset after 3 handshakes of the first case → all outputs 0 immediately. A new _start after release runs a full, correct job.
